// File: rtl/assoc_layer_controller.sv
// Association layer controller.
// Learns (key, response) class pairs into a small table of association
// nodes. A matching pair bumps its node's saturating count, and a new pair
// takes the next free node. A debug read port exposes the table contents.
`timescale 1ns/1ps

module assoc_layer_controller #(
    parameter int CLASS_W   = 8,
    parameter int NUM_NODES = 16,
    parameter int COUNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         assoc_learning_start,
    input  logic [CLASS_W-1:0]           key_class,
    input  logic [CLASS_W-1:0]           resp_class,
    output logic                         assoc_learning_done,
    output logic                         busy,
    output logic [$clog2(NUM_NODES):0]   node_count,
    output logic                         overflow,
    input  logic [$clog2(NUM_NODES)-1:0] rd_idx,
    output logic [CLASS_W-1:0]           rd_key,
    output logic [CLASS_W-1:0]           rd_resp,
    output logic [COUNT_W-1:0]           rd_count,
    output logic                         rd_valid
);

    localparam int IDX_W = $clog2(NUM_NODES);
    localparam int NC_W  = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEARCH,
        UPDATE,
        CREATE,
        DONE,
        WAIT_LOW
    } state_t;

    state_t state;
    state_t next_state;

    logic [CLASS_W-1:0] keys   [NUM_NODES];
    logic [CLASS_W-1:0] resps  [NUM_NODES];
    logic [COUNT_W-1:0] counts [NUM_NODES];

    logic [CLASS_W-1:0] key_q;
    logic [CLASS_W-1:0] resp_q;
    logic [IDX_W-1:0]   idx;

    logic hit;
    logic last;
    logic full;

    assign hit  = (keys[idx] == key_q) && (resps[idx] == resp_q);
    assign last = ({1'b0, idx} == (node_count - NC_W'(1)));
    assign full = (node_count == NC_W'(NUM_NODES));

    assign rd_key   = keys[rd_idx];
    assign rd_resp  = resps[rd_idx];
    assign rd_count = counts[rd_idx];
    assign rd_valid = ({1'b0, rd_idx} < node_count);

    // State register; reset abandons whatever operation is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the Moore status outputs.
    always_comb begin
        next_state          = state;
        busy                = (state != IDLE);
        assoc_learning_done = 1'b0;
        case (state)
            IDLE:     if (assoc_learning_start) next_state = CAPTURE;
            CAPTURE:  next_state = (node_count == '0) ? CREATE : SEARCH;
            SEARCH: begin
                if (hit) begin
                    next_state = UPDATE;
                end else if (last) begin
                    next_state = CREATE;
                end
            end
            UPDATE:   next_state = DONE;
            CREATE:   next_state = DONE;
            DONE: begin
                assoc_learning_done = 1'b1;
                next_state          = WAIT_LOW;
            end
            WAIT_LOW: if (!assoc_learning_start) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Table and scan datapath; at most one table write per operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            node_count <= '0;
            overflow   <= 1'b0;
            idx        <= '0;
            key_q      <= '0;
            resp_q     <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                keys[i]   <= '0;
                resps[i]  <= '0;
                counts[i] <= '0;
            end
        end else begin
            case (state)
                CAPTURE: begin
                    key_q  <= key_class;
                    resp_q <= resp_class;
                    idx    <= '0;
                end
                SEARCH: begin
                    if (!hit && !last) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                UPDATE: begin
                    if (counts[idx] != '1) begin
                        counts[idx] <= counts[idx] + COUNT_W'(1);
                    end
                end
                CREATE: begin
                    if (!full) begin
                        keys[node_count[IDX_W-1:0]]   <= key_q;
                        resps[node_count[IDX_W-1:0]]  <= resp_q;
                        counts[node_count[IDX_W-1:0]] <= COUNT_W'(1);
                        node_count                    <= node_count + NC_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
